hilo_muldiv_unit: RTL and testbench

- Consumer side of the 22-bit control word emitted by the decoder.
- Decodes the HI/LO control fields, runs iterative MULT/MULTU/DIV/DIVU, and owns the architectural HI and LO registers.
- Serves MTHI/MTLO/MFHI/MFLO and stalls the single-cycle datapath while an operation is in flight.
- Sits beside the ALU, fed from the register-file read ports (rs, rt).

---
 rtl/hilo_muldiv_unit.sv | 222 ++++++++++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_unit.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : hilo_muldiv_unit
// Description : HI/LO register owner with iterative shift-add multiply and
//               restoring divide; serves MTHI/MTLO/MFHI/MFLO and stalls the
//               datapath while an operation is in flight.
//               Optional macro HILO_ZERO_SKIP_EN: zero-operand fast path.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------

`ifndef ALU_MUL
`define ALU_MUL 4'b1010
`endif
`ifndef ALU_DIV
`define ALU_DIV 4'b1011
`endif

module hilo_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid,
    input  logic [21:0]     control_word,
    input  logic [XLEN-1:0] rs_data,
    input  logic [XLEN-1:0] rt_data,
    output logic [XLEN-1:0] rd_data,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int c_CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_FIXUP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [c_CNT_W-1:0]  cnt_q, cnt_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     opnd_q, opnd_d;
    logic                is_div_q, is_div_d;
    logic                neg_lo_q, neg_lo_d;
    logic                neg_hi_q, neg_hi_d;
    logic [XLEN-1:0]     hi_q, hi_d;
    logic [XLEN-1:0]     lo_q, lo_d;
    logic                done_q, done_d;

    // Control word decode
    logic       hi_wr, hi_rd, lo_wr, lo_rd, unsigned_op;
    logic [3:0] aluop;
    logic       op_md, is_mul, is_div, mthi, mtlo, mfhi, mflo, hilo_touch;
    logic       unused_cw;

    assign hi_wr       = control_word[21];
    assign hi_rd       = control_word[20];
    assign lo_wr       = control_word[19];
    assign lo_rd       = control_word[18];
    assign unsigned_op = control_word[17];
    assign aluop       = control_word[6:3];
    assign unused_cw   = ^{control_word[16:7], control_word[2:0]};

    assign op_md      = issue_valid & hi_wr & lo_wr;
    assign is_mul     = op_md & (aluop == `ALU_MUL);
    assign is_div     = op_md & (aluop == `ALU_DIV);
    assign mthi       = issue_valid & hi_wr & ~lo_wr;
    assign mtlo       = issue_valid & lo_wr & ~hi_wr;
    assign mfhi       = issue_valid & hi_rd & ~hi_wr;
    assign mflo       = issue_valid & lo_rd & ~lo_wr;
    assign hilo_touch = issue_valid & (|control_word[21:18]);

    // Operand magnitudes for signed operations
    logic            a_neg, b_neg, rt_zero;
    logic [XLEN-1:0] a_mag, b_mag;

    assign a_neg   = ~unsigned_op & rs_data[XLEN-1];
    assign b_neg   = ~unsigned_op & rt_data[XLEN-1];
    assign a_mag   = a_neg ? (-rs_data) : rs_data;
    assign b_mag   = b_neg ? (-rt_data) : rt_data;
    assign rt_zero = (rt_data == '0);

`ifdef HILO_ZERO_SKIP_EN
    logic skip_zero;
    assign skip_zero = is_div ? rt_zero : (rt_zero | (rs_data == '0));
`endif

    // Iteration datapaths: acc holds {upper, lower} for both algorithms
    logic [XLEN:0]   mul_sum;
    logic [XLEN+1:0] div_trial;

    assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign div_trial = {1'b0, acc_q[2*XLEN-1:XLEN-1]} - {2'b00, opnd_q};

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;

    assign prod_fix = neg_lo_q ? (-acc_q) : acc_q;
    assign quo_fix  = neg_lo_q ? (-acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
    assign rem_fix  = neg_hi_q ? (-acc_q[2*XLEN-1:XLEN]) : acc_q[2*XLEN-1:XLEN];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (mthi) hi_d = rs_data;
                if (mtlo) lo_d = rs_data;
                if (is_mul || is_div) begin
                    state_d  = S_CALC;
                    cnt_d    = '0;
                    is_div_d = is_div;
                    if (is_div && rt_zero) begin
                        // A zero divisor shifts the raw dividend into the remainder
                        // and yields an all-ones quotient with no sign correction.
                        acc_d    = {{XLEN{1'b0}}, rs_data};
                        opnd_d   = '0;
                        neg_lo_d = 1'b0;
                        neg_hi_d = 1'b0;
                    end else if (is_div) begin
                        acc_d    = {{XLEN{1'b0}}, a_mag};
                        opnd_d   = b_mag;
                        neg_lo_d = a_neg ^ b_neg;
                        neg_hi_d = a_neg;
                    end else begin
                        acc_d    = {{XLEN{1'b0}}, b_mag};
                        opnd_d   = a_mag;
                        neg_lo_d = a_neg ^ b_neg;
                        neg_hi_d = a_neg ^ b_neg;
                    end
`ifdef HILO_ZERO_SKIP_EN
                    if (skip_zero) begin
                        state_d  = S_FIXUP;
                        acc_d    = is_div ? {rs_data, {XLEN{1'b1}}} : '0;
                        neg_lo_d = 1'b0;
                        neg_hi_d = 1'b0;
                    end
`endif
                end
            end
            S_CALC: begin
                if (is_div_q) begin
                    if (div_trial[XLEN+1])
                        acc_d = {acc_q[2*XLEN-2:0], 1'b0};
                    else
                        acc_d = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
                end else begin
                    acc_d = {mul_sum, acc_q[XLEN-1:1]};
                end
                cnt_d = cnt_q + c_CNT_W'(1);
                if (cnt_q == c_CNT_W'(XLEN-1))
                    state_d = S_FIXUP;
            end
            S_FIXUP: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[2*XLEN-1:XLEN];
                    lo_d = prod_fix[XLEN-1:0];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        rd_data = '0;
        if (mfhi)      rd_data = hi_q;
        else if (mflo) rd_data = lo_q;
    end

    assign busy  = (state_q != S_IDLE);
    assign stall = (busy | (state_q == S_FIXUP)) & hilo_touch;
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_hilo_muldiv_unit.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_hilo_muldiv_unit
// Description : Self-checking bench for hilo_muldiv_unit against an arithmetic
//               reference model; honours HILO_ZERO_SKIP_EN for latency.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------

`ifndef ALU_MUL
`define ALU_MUL 4'b1010
`endif
`ifndef ALU_DIV
`define ALU_DIV 4'b1011
`endif

module tb_hilo_muldiv_unit;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            issue_valid;
    logic [21:0]     control_word;
    logic [XLEN-1:0] rs_data, rt_data;
    logic [XLEN-1:0] rd_data, hi, lo;
    logic            stall, busy, done;

    int n_cmp  = 0;
    int n_fail = 0;

    hilo_muldiv_unit #(.XLEN(XLEN)) dut (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (issue_valid),
        .control_word (control_word),
        .rs_data      (rs_data),
        .rt_data      (rt_data),
        .rd_data      (rd_data),
        .stall        (stall),
        .busy         (busy),
        .done         (done),
        .hi           (hi),
        .lo           (lo)
    );

    always #5 clk = ~clk;

    function automatic logic [21:0] mk_cw(input bit hw, input bit hr, input bit lw,
                                          input bit lr, input bit uns, input logic [3:0] op);
        logic [21:0] cw;
        cw     = '0;
        cw[21] = hw;
        cw[20] = hr;
        cw[19] = lw;
        cw[18] = lr;
        cw[17] = uns;
        cw[6:3] = op;
        return cw;
    endfunction

    // Reference: plain 64-bit arithmetic
    task automatic ref_md(input bit is_div, input bit uns, input logic [31:0] a,
                          input logic [31:0] b, output logic [31:0] h, output logic [31:0] l);
        logic [63:0] p;
        longint sa, sb, sq, sr;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!is_div) begin
            if (uns) p = {32'b0, a} * {32'b0, b};
            else     p = sa * sb;
            h = p[63:32];
            l = p[31:0];
        end else if (b == 32'd0) begin
            h = a;
            l = 32'hFFFF_FFFF;
        end else if (uns) begin
            l = a / b;
            h = a % b;
        end else begin
            sq = sa / sb;
            sr = sa % sb;
            l = sq[31:0];
            h = sr[31:0];
        end
    endtask

    task automatic idle_inputs();
        issue_valid  = 1'b0;
        control_word = '0;
        rs_data      = '0;
        rt_data      = '0;
    endtask

    task automatic do_mt(input bit to_hi, input logic [31:0] v);
        @(negedge clk);
        issue_valid  = 1'b1;
        control_word = mk_cw(to_hi, 1'b0, !to_hi, 1'b0, 1'b0, 4'd0);
        rs_data      = v;
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic run_md(input bit is_div, input bit uns, input logic [31:0] a,
                          input logic [31:0] b, input string tag);
        logic [31:0] eh, el;
        int lat, n;
        bit skip;
        ref_md(is_div, uns, a, b, eh, el);
        skip = 1'b0;
`ifdef HILO_ZERO_SKIP_EN
        skip = is_div ? (b == 32'd0) : (a == 32'd0 || b == 32'd0);
`endif
        lat = skip ? 1 : XLEN + 1;
        @(negedge clk);
        issue_valid  = 1'b1;
        control_word = mk_cw(1'b1, 1'b0, 1'b1, 1'b0, uns, is_div ? `ALU_DIV : `ALU_MUL);
        rs_data      = a;
        rt_data      = b;
        @(posedge clk);
        #1;
        idle_inputs();
        n_cmp++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s busy_after_accept: got %b expected 1", tag, busy);
        end
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        n_cmp++;
        if (n !== lat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d expected %0d", tag, n, lat);
        end
        n_cmp++;
        if (hi !== eh) begin
            n_fail++;
            $display("FAIL %s hi (a=%h b=%h): got %h expected %h", tag, a, b, hi, eh);
        end
        n_cmp++;
        if (lo !== el) begin
            n_fail++;
            $display("FAIL %s lo (a=%h b=%h): got %h expected %h", tag, a, b, lo, el);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s busy_at_done: got %b expected 0", tag, busy);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done_single_pulse: got %b expected 0", tag, done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({hi, lo} !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_hilo: got %h expected 0", {hi, lo});
        end
        n_cmp++;
        if ({busy, done, stall} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 000", {busy, done, stall});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset_midop();
        int seen;
        do_mt(1'b1, 32'h1111_1111);
        do_mt(1'b0, 32'h2222_2222);
        @(negedge clk);
        issue_valid  = 1'b1;
        control_word = mk_cw(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, `ALU_MUL);
        rs_data      = 32'h0000_1234;
        rt_data      = 32'h0000_5678;
        @(posedge clk);
        #1;
        idle_inputs();
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({hi, lo} !== 64'd0) begin
            n_fail++;
            $display("FAIL midop_reset_hilo: got %h expected 0", {hi, lo});
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midop_reset_busy: got %b expected 0", busy);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL midop_reset_no_done: got %0d pulses expected 0", seen);
        end
        @(negedge clk);
        issue_valid  = 1'b1;
        control_word = mk_cw(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        #1;
        n_cmp++;
        if (rd_data !== 32'd0) begin
            n_fail++;
            $display("FAIL midop_reset_mflo: got %h expected 0", rd_data);
        end
        idle_inputs();
        // MT write coinciding with reset must be dropped
        @(negedge clk);
        rst          = 1'b1;
        issue_valid  = 1'b1;
        control_word = mk_cw(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        rs_data      = 32'h5555_5555;
        @(posedge clk);
        #1;
        n_cmp++;
        if (lo !== 32'd0) begin
            n_fail++;
            $display("FAIL mt_with_reset: got %h expected 0", lo);
        end
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
    endtask

    task automatic test_mt_mf();
        logic [31:0] hold_hi, v;
        do_mt(1'b1, 32'h0BAD_BEEF);
        hold_hi = 32'h0BAD_BEEF;
        do_mt(1'b0, 32'hCAFE_F00D);
        n_cmp++;
        if (lo !== 32'hCAFE_F00D) begin
            n_fail++;
            $display("FAIL mtlo_value: got %h expected cafef00d", lo);
        end
        n_cmp++;
        if (hi !== hold_hi) begin
            n_fail++;
            $display("FAIL mtlo_hi_kept: got %h expected %h", hi, hold_hi);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mtlo_busy: got %b expected 0", busy);
        end
        for (int i = 0; i < 4; i++) begin
            v = $urandom;
            do_mt(1'b1, v);
            issue_valid  = 1'b1;
            control_word = mk_cw(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
            #1;
            n_cmp++;
            if (rd_data !== v) begin
                n_fail++;
                $display("FAIL mthi_mfhi: got %h expected %h", rd_data, v);
            end
            control_word = mk_cw(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
            #1;
            n_cmp++;
            if (rd_data !== 32'hCAFE_F00D) begin
                n_fail++;
                $display("FAIL mflo_read: got %h expected cafef00d", rd_data);
            end
            control_word = mk_cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
            #1;
            n_cmp++;
            if (rd_data !== 32'd0) begin
                n_fail++;
                $display("FAIL other_rd_zero: got %h expected 0", rd_data);
            end
            idle_inputs();
        end
    endtask

    task automatic test_directed();
        run_md(1'b0, 1'b0, 32'hFFFF_FFFE, 32'h0000_0003, "mult_neg");
        run_md(1'b0, 1'b1, 32'hFFFF_FFFE, 32'h0000_0003, "multu");
        run_md(1'b1, 1'b0, 32'hFFFF_FFF9, 32'h0000_0002, "div_neg");
        run_md(1'b1, 1'b1, 32'h0000_0007, 32'h0000_0002, "divu");
        run_md(1'b1, 1'b1, 32'h1234_5678, 32'h0000_0000, "divu_zero");
        run_md(1'b1, 1'b0, 32'h8765_4321, 32'h0000_0000, "div_zero");
        run_md(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        run_md(1'b0, 1'b0, 32'h0000_0000, 32'hFFFF_FFF0, "mult_zero");
        run_md(1'b0, 1'b0, 32'h8000_0000, 32'h8000_0000, "mult_min");
        n_cmp++;
        if ({hi, lo} !== 64'h4000_0000_0000_0000) begin
            n_fail++;
            $display("FAIL mult_min_const: got %h expected 4000000000000000", {hi, lo});
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        for (int i = 0; i < 40; i++)
            run_md(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pick(), pick(), "rand");
    endtask

    task automatic test_stall();
        logic [31:0] a, b, eh, el;
        int i;
        bit fin;
        a = $urandom | 32'h0000_0100;
        b = $urandom | 32'h0001_0000;
        ref_md(1'b0, 1'b0, a, b, eh, el);
        @(negedge clk);
        issue_valid  = 1'b1;
        control_word = mk_cw(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, `ALU_MUL);
        rs_data      = a;
        rt_data      = b;
        @(posedge clk);
        fin = 1'b0;
        i = 0;
        while (!fin && i < 100) begin
            @(negedge clk);
            issue_valid = 1'b1;
            rs_data     = 32'hDEAD_0000;
            if (i == 5)       control_word = mk_cw(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
            else if (i == 10) control_word = mk_cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1);
            else              control_word = mk_cw(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
            #1;
            if (busy === 1'b1) begin
                n_cmp++;
                if (stall !== (i != 10)) begin
                    n_fail++;
                    $display("FAIL stall_cycle%0d: got %b expected %b", i, stall, (i != 10));
                end
            end else begin
                fin = 1'b1;
            end
            i++;
        end
        n_cmp++;
        if (!fin || i !== XLEN + 2 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_release: got fin=%b iters=%0d stall=%b expected 1/%0d/0",
                     fin, i, stall, XLEN + 2);
        end
        n_cmp++;
        if (rd_data !== eh) begin
            n_fail++;
            $display("FAIL mfhi_after_busy: got %h expected %h", rd_data, eh);
        end
        n_cmp++;
        if (lo !== el) begin
            n_fail++;
            $display("FAIL stall_lo: got %h expected %h", lo, el);
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_reset_midop();
        test_mt_mf();
        test_directed();
        test_stall();
        test_random();
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
